// File: rtl/compl_serial.sv
// Bit-serial complement unit: pass, one's complement, two's complement or absolute
// value of a WIDTH-bit operand, one bit per cycle LSB first, with an overflow flag.
module compl_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] inp,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q;
  logic             inv_q;
  logic             ovf_pend_q;

  logic             twos_c;
  logic             inv_c;
  logic             bit_c;
  logic             rbit_c;
  logic [WIDTH-1:0] res_next_c;
  logic             last_c;

  // Operation decode on the live inputs (only used at capture) and one serial bit-step.
  always_comb begin
    twos_c     = (mode == 2'b10) || ((mode == 2'b11) && inp[WIDTH-1]);
    inv_c      = twos_c || (mode == 2'b01);
    bit_c      = sh_q[0] ^ inv_q;
    rbit_c     = bit_c ^ carry_q;
    res_next_c = {rbit_c, res_q[WIDTH-1:1]};
    last_c     = (cnt_q == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      sh_q       <= '0;
      res_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      inv_q      <= 1'b0;
      ovf_pend_q <= 1'b0;
      out        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_q       <= inp;
            res_q      <= '0;
            cnt_q      <= '0;
            inv_q      <= inv_c;
            carry_q    <= twos_c;
            // Negating the most-negative value wraps back onto itself.
            ovf_pend_q <= twos_c && (inp == MIN_NEG);
            busy       <= 1'b1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          sh_q    <= sh_q >> 1;
          res_q   <= res_next_c;
          carry_q <= bit_c & carry_q;
          cnt_q   <= cnt_q + CW'(1);
          if (last_c) begin
            out   <= res_next_c;
            ovf   <= ovf_pend_q;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compl_serial.sv
// Self-checking bench for compl_serial at WIDTH=4 and WIDTH=8 against an
// arithmetic reference model (negation by subtraction, not bit-serial).
module tb_compl_serial;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start4 = 1'b0, start8 = 1'b0;
  logic [3:0] inp4 = '0;
  logic [7:0] inp8 = '0;
  logic [1:0] mode4 = '0, mode8 = '0;
  logic [3:0] out4;
  logic [7:0] out8;
  logic       busy4, done4, ovf4;
  logic       busy8, done8, ovf8;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  compl_serial #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .inp(inp4), .mode(mode4),
    .out(out4), .busy(busy4), .done(done4), .ovf(ovf4)
  );

  compl_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .inp(inp8), .mode(mode8),
    .out(out8), .busy(busy8), .done(done8), .ovf(ovf8)
  );

  // Reference: {ovf, result} from plain arithmetic on a w-bit operand.
  function automatic logic [8:0] model(input int w, input logic [7:0] a, input logic [1:0] m);
    int  mask, x, r;
    bit  twos;
    mask = (1 << w) - 1;
    x    = int'(a) & mask;
    twos = (m == 2'b10) || (m == 2'b11 && ((x >> (w - 1)) & 1) == 1);
    if (m == 2'b01)  r = ~x;
    else if (twos)   r = -x;
    else             r = x;
    r = r & mask;
    model = {twos && (x == (1 << (w - 1))), 8'(r)};
  endfunction

  // Drives one operation; lat counts edges from the start-sampling edge to the one raising done.
  task automatic run_op(input bit w8, input logic [7:0] a, input logic [1:0] m,
                        output logic [7:0] o, output logic f, output int lat,
                        output int ndone, output bit early);
    logic [7:0] prev, cur;
    int cyc;
    bit dn, bs;
    @(negedge clk);
    prev = w8 ? out8 : {4'b0, out4};
    if (w8) begin inp8 = a; mode8 = m; start8 = 1'b1; end
    else begin inp4 = a[3:0]; mode4 = m; start4 = 1'b1; end
    o = prev; f = 1'b0; lat = -1; ndone = 0; early = 1'b0; cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        start4 = 1'b0; start8 = 1'b0;
        inp4 = 4'($urandom); mode4 = 2'($urandom);
        inp8 = 8'($urandom); mode8 = 2'($urandom);
      end
      dn  = w8 ? done8 : done4;
      bs  = w8 ? busy8 : busy4;
      cur = w8 ? out8 : {4'b0, out4};
      if (dn) begin
        ndone++; lat = cyc; o = cur; f = w8 ? ovf8 : ovf4;
      end else if (ndone == 0 && cur !== prev) begin
        early = 1'b1;
      end
      if (!bs) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({out4, busy4, done4, ovf4} !== 7'b0) $display("FAIL reset4 got out=%b busy=%b done=%b ovf=%b want all 0", out4, busy4, done4, ovf4);
    else pass_cnt++;
    total_cnt++;
    if ({out8, busy8, done8, ovf8} !== 11'b0) $display("FAIL reset8 got out=%b busy=%b done=%b ovf=%b want all 0", out8, busy8, done8, ovf8);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [7:0] a_tab [8] = '{8'h5, 8'h5, 8'h1, 8'h8, 8'h0, 8'hE, 8'h6, 8'h9};
    logic [1:0] m_tab [8] = '{2'b01, 2'b00, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
    logic [7:0] e_tab [8] = '{8'hA, 8'h5, 8'hF, 8'h8, 8'h0, 8'h2, 8'h6, 8'h7};
    logic       v_tab [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [7:0] o; logic f; int lat, nd; bit early;
    for (int i = 0; i < 8; i++) begin
      run_op(1'b0, a_tab[i], m_tab[i], o, f, lat, nd, early);
      total_cnt++;
      if ({f, o} !== {v_tab[i], e_tab[i]}) $display("FAIL directed[%0d] inp=%h mode=%b got ovf=%b out=%h want ovf=%b out=%h", i, a_tab[i], m_tab[i], f, o, v_tab[i], e_tab[i]);
      else pass_cnt++;
      total_cnt++;
      if (lat != 5 || nd != 1 || early) $display("FAIL directed_timing[%0d] got lat=%0d dones=%0d early=%b want lat=5 dones=1 early=0", i, lat, nd, early);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignore_start();
    int nd = 0;
    @(negedge clk);
    inp4 = 4'b0101; mode4 = 2'b01; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    inp4 = 4'b0011; mode4 = 2'b00; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (done4) nd++;
    end
    total_cnt++;
    if (out4 !== 4'b1010 || nd != 1 || busy4 !== 1'b0) $display("FAIL ignore_start got out=%b dones=%0d busy=%b want out=1010 dones=1 busy=0", out4, nd, busy4);
    else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [7:0] o; logic f; int lat, nd = 0; bit early;
    run_op(1'b0, 8'h8, 2'b10, o, f, lat, nd, early);
    nd = 0;
    @(negedge clk);
    inp4 = 4'b0101; mode4 = 2'b01; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    if (done4) nd++;
    total_cnt++;
    if ({out4, busy4, done4, ovf4} !== 7'b0 || nd != 0) $display("FAIL reset_abort got out=%b busy=%b done=%b ovf=%b want all 0", out4, busy4, done4, ovf4);
    else pass_cnt++;
    reset = 1'b0;
    run_op(1'b0, 8'h6, 2'b10, o, f, lat, nd, early);
    total_cnt++;
    if (o !== 8'hA || f !== 1'b0 || lat != 5 || nd != 1 || early) $display("FAIL after_reset got out=%h ovf=%b lat=%0d dones=%0d want out=a ovf=0 lat=5 dones=1", o, f, lat, nd);
    else pass_cnt++;
  endtask

  task automatic test_width8();
    logic [7:0] o, a; logic [1:0] m; logic f; int lat, nd; bit early;
    logic [8:0] exp;
    run_op(1'b1, 8'h80, 2'b11, o, f, lat, nd, early);
    total_cnt++;
    if (o !== 8'h80 || f !== 1'b1 || lat != 9 || nd != 1 || early) $display("FAIL w8_minneg got out=%h ovf=%b lat=%0d dones=%0d want out=80 ovf=1 lat=9 dones=1", o, f, lat, nd);
    else pass_cnt++;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom); m = 2'($urandom);
      exp = model(8, a, m);
      run_op(1'b1, a, m, o, f, lat, nd, early);
      total_cnt++;
      if ({f, o} !== exp || lat != 9 || nd != 1 || early) $display("FAIL w8_rand inp=%h mode=%b got ovf=%b out=%h lat=%0d want ovf=%b out=%h lat=9", a, m, f, o, lat, exp[8], exp[7:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_sweep4();
    logic [7:0] o; logic f; int lat, nd; bit early;
    logic [8:0] exp;
    for (int a = 0; a < 16; a++) begin
      for (int m = 0; m < 4; m++) begin
        exp = model(4, 8'(a), 2'(m));
        run_op(1'b0, 8'(a), 2'(m), o, f, lat, nd, early);
        total_cnt++;
        if ({f, o} !== exp || lat != 5 || nd != 1 || early) $display("FAIL sweep4 inp=%h mode=%0d got ovf=%b out=%h lat=%0d want ovf=%b out=%h lat=5", a, m, f, o, lat, exp[8], exp[7:0]);
        else pass_cnt++;
      end
    end
  endtask

  // Consecutive ops with start raised in the first idle cycle; period must be WIDTH+2.
  task automatic test_back_to_back();
    logic [7:0] o, a; logic [1:0] m; logic f; int lat, nd; bit early;
    logic [8:0] exp;
    time t0, t1;
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom_range(0, 15)); m = 2'($urandom);
      exp = model(4, a, m);
      t0 = $time;
      run_op(1'b0, a, m, o, f, lat, nd, early);
      t1 = $time;
      total_cnt++;
      if ({f, o} !== exp || nd != 1 || early) $display("FAIL b2b inp=%h mode=%b got ovf=%b out=%h want ovf=%b out=%h", a, m, f, o, exp[8], exp[7:0]);
      else pass_cnt++;
      if (i > 0) begin
        total_cnt++;
        if (t1 - t0 != 60) $display("FAIL b2b_period got %0t want 60", t1 - t0);
        else pass_cnt++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_reset_abort();
    test_width8();
    test_sweep4();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/compl_serial.md
COMPL_SERIAL -- requirements
Module: compl_serial

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port start  input  1  request pulse; sampled only in IDLE.
REQ-005 SHALL provide port inp  input  WIDTH  operand, captured on accepted start.
REQ-006 SHALL provide port mode  input  2  operation select, captured on accepted start: 00 pass, 01 one's complement, 10 two's complement, 11 absolute value (two's complement only if inp MSB=1).
REQ-007 SHALL provide port out  output  WIDTH  registered result; holds last completed result.
REQ-008 SHALL provide port busy  output  1  high while an operation is in progress.
REQ-009 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-010 SHALL provide port ovf  output  1  registered overflow flag for the last completed result.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE; IDLE->SHIFT on start=1; SHIFT->DONE after WIDTH bit-steps; DONE->IDLE unconditionally after one cycle.
REQ-012 SHALL, on accepted start, latch inp into a shift register, latch mode, clear the bit counter, and set carry=1 if the effective operation is two's complement, else carry=0.
REQ-013 SHALL treat mode 11 as two's complement when latched inp[WIDTH-1]=1, else as pass.
REQ-014 SHALL process one bit per SHIFT cycle, LSB first: b' = b for pass, ~b otherwise; result bit = b' XOR carry; next carry = b' AND carry.
REQ-015 SHALL shift each result bit into the MSB of an internal result register, so after WIDTH steps bit order equals the operand's.
REQ-016 SHALL load out and ovf on the edge that performs the final (WIDTH-th) bit-step; out SHALL be unchanged at all other times.
REQ-017 SHALL assert done for exactly one cycle, WIDTH+1 cycles after the edge that sampled start (WIDTH=4: 5 cycles).
REQ-018 SHALL hold busy=1 from the cycle after start is accepted until and including the done cycle; busy=0 in IDLE.
REQ-019 SHALL ignore start while in SHIFT or DONE (no restart, no re-capture of inp/mode).
REQ-020 SHALL accept a new start in the cycle after done (IDLE), giving back-to-back operations every WIDTH+2 cycles.
REQ-021 SHALL set ovf=1 only when the effective operation is two's complement and latched inp = 1 followed by WIDTH-1 zeros (most-negative value); result in that case equals inp.
REQ-022 SHALL set ovf=0 for pass, one's complement, and all other inputs.
REQ-023 SHALL ignore changes on inp and mode after capture.

Reset
REQ-024 SHALL, when reset=1 at a rising edge, force state IDLE, out=0, busy=0, done=0, ovf=0, counter=0, carry=0.
REQ-025 SHALL give reset priority over start and over any in-progress operation; an aborted operation SHALL NOT update out or pulse done.
REQ-026 SHALL accept start on the first edge with reset=0.

Verification
REQ-027 SHALL verify WIDTH=4: inp=0101, mode=01, start -> done 5 cycles later, out=1010, ovf=0; mode=00 same inp -> out=0101.
REQ-028 SHALL verify WIDTH=4 two's complement: inp=0001, mode=10 -> out=1111, ovf=0; inp=1000, mode=10 -> out=1000, ovf=1; inp=0000, mode=10 -> out=0000, ovf=0.
REQ-029 SHALL verify absolute value: inp=1110, mode=11 -> out=0010; inp=0110, mode=11 -> out=0110, ovf=0.
REQ-030 SHALL verify start pulsed with inp=0011 during SHIFT of an operation on 0101/mode 01 -> ignored, out=1010, single done pulse.
REQ-031 SHALL verify reset asserted on 2nd SHIFT cycle -> next cycle busy=0, out=0, no done; following start completes normally.
REQ-032 SHALL verify WIDTH=8: inp=10000000, mode=11 -> out=10000000, ovf=1, done 9 cycles after start; plus exhaustive 4-bit sweep of all inp x mode against a reference model.
